// File: rtl/hazard_stall_ctrl.sv
// Hazard unit for the 5-stage MIPS pipeline: operand forwarding selects, load-use and
// branch stalls, branch/jump flushes, and the multi-cycle mult/div occupancy FSM.
module hazard_stall_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] writereg_e,
    input  logic [REG_AW-1:0] writereg_m,
    input  logic [REG_AW-1:0] writereg_w,
    input  logic              regwrite_e,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              memtoreg_e,
    input  logic              memtoreg_m,
    input  logic              branch_d,
    input  logic              pcsrc_d,
    input  logic              jump_d,
    input  logic              mdu_start_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              fwd_a_d,
    output logic              fwd_b_d,
    output logic              mdu_busy
);

    localparam int CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;

    logic       w_lwstall;
    logic       w_branchstall;
    logic       w_mdu_stall;
    logic       w_stall_fd;
    logic [1:0] w_fwd_a_e;
    logic [1:0] w_fwd_b_e;

    // Register 0 is hard-wired, so a source field of zero never hits.
    function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (regwrite_m && hit(src, writereg_m))
            return 2'b10;
        else if (regwrite_w && hit(src, writereg_w))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_fwd_a_e     = fwd_sel(rs_e);
        w_fwd_b_e     = fwd_sel(rt_e);
        w_lwstall     = memtoreg_e && regwrite_e &&
                        (hit(rs_d, writereg_e) || hit(rt_d, writereg_e));
        w_branchstall = branch_d &&
                        ((regwrite_e && (hit(rs_d, writereg_e) || hit(rt_d, writereg_e))) ||
                         (memtoreg_m && (hit(rs_d, writereg_m) || hit(rt_d, writereg_m))));
        w_mdu_stall   = ((r_state == IDLE) && mdu_start_e) || (r_state == BUSY);
        w_stall_fd    = w_lwstall || w_branchstall || w_mdu_stall;
    end

    // Outputs are forced low while reset is asserted, independent of the clock.
    assign stall_f  = rst & w_stall_fd;
    assign stall_d  = rst & w_stall_fd;
    assign stall_e  = rst & w_mdu_stall;
    assign flush_m  = rst & w_mdu_stall;
    assign mdu_busy = rst & w_mdu_stall;
    assign flush_e  = rst & (w_lwstall | w_branchstall) & ~w_mdu_stall;
    assign flush_d  = rst & (pcsrc_d | jump_d) & ~w_stall_fd;
    assign fwd_a_e  = {2{rst}} & w_fwd_a_e;
    assign fwd_b_e  = {2{rst}} & w_fwd_b_e;
    assign fwd_a_d  = rst & regwrite_m & hit(rs_d, writereg_m);
    assign fwd_b_d  = rst & regwrite_m & hit(rt_d, writereg_m);

    // DONE ignores mdu_start_e: the finishing mult/div is still sitting in E.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mdu_start_e) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0)
                        r_state <= DONE;
                    else
                        r_cnt <= r_cnt - CW'(1);
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl: stimulus pushes expected control
// vectors, a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
    logic       branch_d, pcsrc_d, jump_d, mdu_start_e;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       fwd_a_d, fwd_b_d, mdu_busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [12:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MDU_LATENCY(4), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .branch_d(branch_d), .pcsrc_d(pcsrc_d), .jump_d(jump_d), .mdu_start_e(mdu_start_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .mdu_busy(mdu_busy)
    );

    // Packed order: sf sd se fd fe fm fae[2] fbe[2] fad fbd busy
    function automatic logic [12:0] ev(input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic fm,
                                       input logic [1:0] fae, input logic [1:0] fbe,
                                       input logic fad, input logic fbd, input logic busy);
        return {sf, sd, se, fd, fe, fm, fae, fbe, fad, fbd, busy};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w} = '0;
        {regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m} = '0;
        {branch_d, pcsrc_d, jump_d, mdu_start_e} = '0;
    endtask

    task automatic expect_v(input string nm, input logic [12:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        logic [12:0] act;
        logic [12:0] exp_v;
        string       nm;
        act = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, mdu_busy};
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            n_cmp++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL %s: got %b expected %b (sf sd se fd fe fm fae fbe fad fbd busy)",
                         nm, act, exp_v);
            end
        end
    end

    localparam logic [12:0] ZERO = '0;
    localparam logic [12:0] MDU  = 13'b1_1_1_0_0_1_00_00_0_0_1;

    initial begin
        rst = 1'b0;
        clr();
        cyc();
        rs_e = 5; regwrite_m = 1; writereg_m = 5; mdu_start_e = 1; pcsrc_d = 1;
        expect_v("reset_all_zero", ZERO);
        cyc(); rst = 1'b1; clr();
        expect_v("idle_after_reset", ZERO);

        cyc(); rs_e = 5; rt_e = 5; regwrite_m = 1; writereg_m = 5; regwrite_w = 1; writereg_w = 5;
        expect_v("fwd_m_priority", ev(0,0,0,0,0,0,2'b10,2'b10,0,0,0));
        cyc(); regwrite_m = 0;
        expect_v("fwd_w", ev(0,0,0,0,0,0,2'b01,2'b01,0,0,0));
        cyc(); rs_e = 0; rt_e = 0; regwrite_m = 1;
        expect_v("fwd_r0", ZERO);
        cyc(); clr(); rs_e = 4; rt_e = 9; regwrite_m = 1; writereg_m = 4; regwrite_w = 1; writereg_w = 9;
        expect_v("fwd_mixed", ev(0,0,0,0,0,0,2'b10,2'b01,0,0,0));
        cyc(); clr(); rs_d = 7; rt_d = 6; regwrite_m = 1; writereg_m = 7;
        expect_v("fwd_d_rs", ev(0,0,0,0,0,0,2'b00,2'b00,1,0,0));

        cyc(); clr(); memtoreg_e = 1; regwrite_e = 1; writereg_e = 8; rs_d = 8;
        expect_v("lwstall_rs", ev(1,1,0,0,1,0,2'b00,2'b00,0,0,0));
        cyc(); rs_d = 9; rt_d = 8;
        expect_v("lwstall_rt", ev(1,1,0,0,1,0,2'b00,2'b00,0,0,0));
        cyc(); rt_d = 9;
        expect_v("lw_no_hazard", ZERO);
        cyc(); writereg_e = 0; rs_d = 0; rt_d = 0;
        expect_v("lw_r0", ZERO);

        cyc(); clr(); branch_d = 1; pcsrc_d = 1; memtoreg_m = 1; writereg_m = 3; rt_d = 3;
        expect_v("branchstall_m_load", ev(1,1,0,0,1,0,2'b00,2'b00,0,0,0));
        cyc(); memtoreg_m = 0;
        expect_v("branch_taken_flush", ev(0,0,0,1,0,0,2'b00,2'b00,0,0,0));
        cyc(); clr(); branch_d = 1; regwrite_e = 1; writereg_e = 2; rs_d = 2;
        expect_v("branchstall_e", ev(1,1,0,0,1,0,2'b00,2'b00,0,0,0));
        cyc(); clr(); jump_d = 1;
        expect_v("jump_flush", ev(0,0,0,1,0,0,2'b00,2'b00,0,0,0));

        cyc(); clr(); mdu_start_e = 1;
        expect_v("mdu_c1", MDU);
        for (int i = 2; i <= 4; i++) begin
            cyc(); expect_v($sformatf("mdu_c%0d", i), MDU);
        end
        cyc(); expect_v("mdu_done", ZERO);
        cyc(); mdu_start_e = 0;
        expect_v("mdu_idle_no_rearm", ZERO);

        cyc(); mdu_start_e = 1;
        expect_v("mdu2_start", MDU);
        cyc(); memtoreg_e = 1; regwrite_e = 1; writereg_e = 8; rs_d = 8;
        expect_v("mdu_with_lwstall", MDU);
        cyc(); rst = 1'b0;
        expect_v("reset_mid_busy", ZERO);
        cyc(); rst = 1'b1; clr();
        expect_v("idle_after_abort", ZERO);

        cyc(); mdu_start_e = 1;
        expect_v("mdu3_c1", MDU);
        for (int i = 2; i <= 4; i++) begin
            cyc(); expect_v($sformatf("mdu3_c%0d", i), MDU);
        end
        cyc(); expect_v("mdu3_done", ZERO);
        cyc(); clr();
        expect_v("final_idle", ZERO);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Produces the enable (stall) and clear (flush) controls consumed by the enable/clear pipeline registers of the 5-stage MIPS pipeline.
- Also produces the forwarding-mux selects for E and the D-stage branch comparator.
- Contains a multi-cycle multiply/divide (MDU) occupancy FSM that holds F/D/E and injects bubbles into M while a mult/div executes.
- Sits beside the datapath, fed by register fields and control bits of the D/E/M/W stages.

Parameters:
- MDU_LATENCY, 4, stall cycles per mult/div instruction. Legal values are ≥2.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- rs_d, rt_d  in  REG_AW  D-stage source registers
- rs_e, rt_e  in  REG_AW  E-stage source registers
- writereg_e, writereg_m, writereg_w  in  REG_AW  destination register per stage
- regwrite_e, regwrite_m, regwrite_w  in  1  stage writes the register file
- memtoreg_e, memtoreg_m  in  1  stage holds a load
- branch_d  in  1  D holds a branch
- pcsrc_d  in  1  branch taken (resolved in D)
- jump_d  in  1  D holds a jump
- mdu_start_e  in  1  E holds mult/div
- stall_f, stall_d, stall_e  out  1  hold F/D/E register (register en = ~stall)
- flush_d, flush_e, flush_m  out  1  clear D/E/M register
- fwd_a_e, fwd_b_e  out  2  E operand select: 00 register file, 10 from M, 01 from W
- fwd_a_d, fwd_b_d  out  1  branch-compare operand taken from M
- mdu_busy  out  1  MDU stall active

Behaviour:
- **Register 0:** never matches for forwarding or hazards. Any compare with rsX/rtX == 0 is false.
- **E forwarding (fwd_a_e, shown for rs_e; rt_e identical):**
  - 10 if regwrite_m && writereg_m==rs_e.
  - Else 01 if regwrite_w && writereg_w==rs_e.
  - Else 00. M has priority over W.
- **D forwarding:** fwd_a_d = regwrite_m && writereg_m==rs_d. fwd_b_d uses rt_d.
- **lwstall:** memtoreg_e && regwrite_e && writereg_e ∈ {rs_d, rt_d}.
- **branchstall:** branch_d && one of the following:
  - regwrite_e && writereg_e ∈ {rs_d, rt_d}
  - memtoreg_m && writereg_m ∈ {rs_d, rt_d}
- **MDU FSM:** states IDLE, BUSY, DONE; counter cnt, width $clog2(MDU_LATENCY).
  - IDLE & mdu_start_e: cnt <= MDU_LATENCY-2, go to BUSY.
  - BUSY: if cnt==0 go to DONE, else cnt <= cnt-1.
  - DONE: go to IDLE unconditionally. mdu_start_e is ignored, because the same instruction is still in E for this cycle.
- **mdu_stall (combinational):** (IDLE & mdu_start_e) | BUSY. This gives exactly MDU_LATENCY stall cycles, and the mult/div occupies E for MDU_LATENCY+1 cycles.
- **Output equations:**
  - mdu_busy = mdu_stall.
  - stall_f = stall_d = lwstall | branchstall | mdu_stall.
  - stall_e = mdu_stall.
  - flush_m = mdu_stall (bubble into M while E is held).
  - flush_e = (lwstall | branchstall) & ~mdu_stall. E is never cleared while it holds the MDU op.
  - flush_d = (pcsrc_d | jump_d) & ~stall_d. Stall wins: the branch is re-evaluated once its operands are ready.
- **Outputs are combinational** from the inputs and the FSM state. No added latency.
- **Reset:**
  - While rst==0, all outputs are 0 and the FSM is forced to IDLE with cnt=0.
  - Reset asserted mid-MDU aborts the operation.
  - After release the FSM starts in IDLE. If mdu_start_e is high on that first cycle, a new MDU sequence starts.
- **Simultaneous events:**
  - lwstall or branchstall together with mdu_stall: stalls are OR-ed and flush_e is suppressed.
  - Back-to-back mult/div: the second one starts only after DONE → IDLE, once it has entered E.

Test Plan:
- Forwarding priority: rs_e=5, regwrite_m=1, writereg_m=5, regwrite_w=1, writereg_w=5 -> fwd_a_e=10. Then regwrite_m=0 -> 01. Then rs_e=0 with both matching -> 00.
- Load-use: memtoreg_e=regwrite_e=1, writereg_e=8, rs_d=8 -> stall_f=stall_d=flush_e=1, stall_e=0. With rs_d=rt_d=9 -> all 0.
- Branch hazard and flush: branch_d=1, pcsrc_d=1, memtoreg_m=1, writereg_m=3, rt_d=3 -> stall_d=1, flush_d=0. Next cycle memtoreg_m=0 -> stall_d=0, flush_d=1. jump_d=1 alone -> flush_d=1.
- MDU, MDU_LATENCY=4: mdu_start_e held high -> mdu_busy/stall_e/flush_m=1 for exactly 4 cycles, then 0 for 1 cycle (DONE), then re-arm only if a new op is in E. flush_e stays 0 throughout.
- MDU overlapped with load-use: lwstall=1 during BUSY -> stall_f=stall_d=1, flush_e=0, flush_m=1.
- Reset mid-operation: rst=0 on the 2nd BUSY cycle -> all outputs 0 immediately (asynchronous). Release with mdu_start_e=0 -> IDLE, mdu_busy=0.
